// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Split-handshake data bus between the memory access unit (master) and the
// data memory / cache (slave).
//
//   data_req      master->slave  request valid
//   data_wr       master->slave  1 = store, 0 = load
//   data_size     master->slave  0 byte, 1 half, 2 word
//   data_addr     master->slave  byte address (unmodified)
//   data_wstrb    master->slave  byte-lane write strobes
//   data_wdata    master->slave  lane-replicated store data
//   data_addr_ok  slave->master  request accepted this cycle
//   data_data_ok  slave->master  read data / write ack valid this cycle
//   data_rdata    slave->master  read data
//
// Handshake: a request transfers in a cycle where data_req && data_addr_ok.
// The response for an accepted request is a single-cycle data_data_ok pulse,
// which may coincide with data_addr_ok or arrive any number of cycles later.
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory stage between EX and WB. Accepts one op at a time from EX, checks
// alignment, issues the access on the split-handshake data bus, extracts and
// extends sub-word load data, encodes store strobes/data and hands a single
// result (or exception with fault address) to WB. A watchdog converts a
// missing data response into a bus-error exception.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               pipeline flush, highest priority
//   in_valid/in_ready   EX -> unit op handshake
//   in_op/in_addr/in_wdata/in_rf_we/in_rf_waddr   op fields from EX
//   bus                 data bus (master side)
//   out_valid/out_ready unit -> WB result handshake
//   out_rf_we/out_rf_waddr/out_rf_wdata           register write-back
//   out_exc/out_badvaddr                          exception code and address
//   dbg_state           current FSM state (IDLE=0, REQ=1, WAIT=2, RESP=3)
//
// Valid/ready: a transfer happens in a cycle where valid && ready are both
// high at the rising clock edge; the sender holds its payload stable while
// valid is high and ready is low. in_ready and out_valid never depend on
// in_valid or out_ready combinationally.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int         ADDR_W   = 32,
    parameter int         TIMEOUT  = 255,
    parameter logic [4:0] EXC_ADEL = 5'h04,
    parameter logic [4:0] EXC_ADES = 5'h05,
    parameter logic [4:0] EXC_DBE  = 5'h07
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic              in_rf_we,
    input  logic [4:0]        in_rf_waddr,

    mem_access_unit_if.master bus,

    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_rf_we,
    output logic [4:0]        out_rf_waddr,
    output logic [31:0]       out_rf_wdata,
    output logic [4:0]        out_exc,
    output logic [ADDR_W-1:0] out_badvaddr,

    output logic [1:0]        dbg_state
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Op decode helpers
    // ------------------------------------------------------------------
    function automatic logic op_is_load(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LW, OP_SW:         return 2'd2;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd0;
        endcase
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

    // Little-endian lane select followed by sign/zero extension.
    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lo,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_SB:   return 4'b0001 << lo;
            OP_SH:   return 4'b0011 << lo;
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wd);
        case (op)
            OP_SB:   return {4{wd[7:0]}};
            OP_SH:   return {2{wd[15:0]}};
            OP_SW:   return wd;
            default: return 32'h0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              orphan_q, orphan_d;   // one outstanding response to discard
    logic [WD_W-1:0]   wd_q, wd_d;

    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;

    logic              res_we_q, res_we_d;
    logic [31:0]       res_wdata_q, res_wdata_d;
    logic [4:0]        res_exc_q, res_exc_d;
    logic [ADDR_W-1:0] res_bad_q, res_bad_d;

    logic              accept;
    logic              req_active;
    logic              bus_fire;
    logic              capture;

    assign in_ready   = (state_q == S_IDLE) && !flush && !rst;
    assign accept     = in_valid && in_ready;
    // An orphaned response must drain before a new request goes out, so the
    // next data_ok can be attributed unambiguously.
    assign req_active = (state_q == S_REQ) && !orphan_q;
    assign bus_fire   = req_active && bus.data_addr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            orphan_q    <= 1'b0;
            wd_q        <= '0;
            op_q        <= OP_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            res_we_q    <= 1'b0;
            res_wdata_q <= '0;
            res_exc_q   <= '0;
            res_bad_q   <= '0;
        end else begin
            state_q     <= state_d;
            orphan_q    <= orphan_d;
            wd_q        <= wd_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            res_we_q    <= res_we_d;
            res_wdata_q <= res_wdata_d;
            res_exc_q   <= res_exc_d;
            res_bad_q   <= res_bad_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        orphan_d    = orphan_q;
        wd_d        = wd_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rf_we_d     = rf_we_q;
        rf_waddr_d  = rf_waddr_q;
        res_we_d    = res_we_q;
        res_wdata_d = res_wdata_q;
        res_exc_d   = res_exc_q;
        res_bad_d   = res_bad_q;
        capture     = 1'b0;

        // The first data_ok after an abandoned request belongs to that request.
        if (orphan_q && bus.data_data_ok) begin
            orphan_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = in_op;
                    addr_d     = in_addr;
                    wdata_d    = in_wdata;
                    rf_we_d    = in_rf_we;
                    rf_waddr_d = in_rf_waddr;
                    if (!op_is_load(in_op) && !op_is_store(in_op)) begin
                        res_we_d    = in_rf_we;
                        res_wdata_d = 32'(in_addr);
                        res_exc_d   = '0;
                        res_bad_d   = '0;
                        state_d     = S_RESP;
                    end else if (op_misaligned(in_op, in_addr[1:0])) begin
                        res_we_d    = 1'b0;
                        res_wdata_d = '0;
                        res_exc_d   = op_is_load(in_op) ? EXC_ADEL : EXC_ADES;
                        res_bad_d   = in_addr;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (flush) begin
                    // A request accepted this cycle without its response leaves
                    // a response in flight that must be discarded later.
                    if (bus_fire && !bus.data_data_ok) begin
                        orphan_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (bus_fire) begin
                    if (bus.data_data_ok) begin
                        capture = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        wd_d    = '0;
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (flush) begin
                    if (!bus.data_data_ok) begin
                        orphan_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (bus.data_data_ok) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else if (wd_q == WD_W'(TIMEOUT)) begin
                    res_we_d    = 1'b0;
                    res_wdata_d = '0;
                    res_exc_d   = EXC_DBE;
                    res_bad_d   = addr_q;
                    orphan_d    = 1'b1;
                    state_d     = S_RESP;
                end
            end

            S_RESP: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            if (op_is_load(op_q)) begin
                res_we_d    = rf_we_q;
                res_wdata_d = load_extract(op_q, addr_q[1:0], bus.data_rdata);
            end else begin
                res_we_d    = 1'b0;
                res_wdata_d = '0;
            end
            res_exc_d = '0;
            res_bad_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bus fields only carry data while a request is driven,
    // result fields only while the result is presented.
    // ------------------------------------------------------------------
    assign bus.data_req   = req_active;
    assign bus.data_wr    = req_active && op_is_store(op_q);
    assign bus.data_size  = req_active ? op_size(op_q) : 2'd0;
    assign bus.data_addr  = req_active ? addr_q : '0;
    assign bus.data_wstrb = req_active ? store_strb(op_q, addr_q[1:0]) : 4'h0;
    assign bus.data_wdata = req_active ? store_data(op_q, wdata_q) : 32'h0;

    assign out_valid    = (state_q == S_RESP);
    assign out_rf_we    = out_valid && res_we_q;
    assign out_rf_waddr = out_valid ? rf_waddr_q : 5'd0;
    assign out_rf_wdata = out_valid ? res_wdata_q : 32'h0;
    assign out_exc      = out_valid ? res_exc_q : 5'd0;
    assign out_badvaddr = out_valid ? res_bad_q : '0;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed table of single ops with hand-computed results, followed by
// hand-written sequences for timeout/orphan handling, flushes in each state
// and asynchronous reset. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_wdata;
    logic              in_rf_we;
    logic [4:0]        in_rf_waddr;
    logic              out_valid;
    logic              out_ready;
    logic              out_rf_we;
    logic [4:0]        out_rf_waddr;
    logic [31:0]       out_rf_wdata;
    logic [4:0]        out_exc;
    logic [ADDR_W-1:0] out_badvaddr;
    logic [1:0]        dbg_state;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_rf_we    (in_rf_we),
        .in_rf_waddr (in_rf_waddr),
        .bus         (bus.master),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rf_we   (out_rf_we),
        .out_rf_waddr(out_rf_waddr),
        .out_rf_wdata(out_rf_wdata),
        .out_exc     (out_exc),
        .out_badvaddr(out_badvaddr),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] rdata;
        int          lat;        // cycles from addr_ok to data_ok
        logic        exp_req;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [3:0]  exp_strb;
        logic [31:0] exp_bdata;
        logic        exp_we;
        logic        chk_wdata;
        logic [31:0] exp_res;
        logic [4:0]  exp_exc;
        logic [31:0] exp_bad;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        in_valid = 1'b0; in_op = OP_NONE; in_addr = '0; in_wdata = '0;
        in_rf_we = 1'b0; in_rf_waddr = '0;
    endtask

    // Presents one op and returns at the falling edge after it was accepted.
    task automatic accept_op(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic rf_we,
                             input logic [4:0] waddr);
        @(negedge clk);
        check("accept_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata;
        in_rf_we = rf_we; in_rf_waddr = waddr;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic wb_take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("wb_done_valid", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        accept_op(v.op, v.addr, v.wdata, v.rf_we, v.waddr);
        exp_q.push_back(v.exp_res);
        if (v.exp_req) begin
            check({tag, "_req"}, {31'b0, bus.data_req}, 32'd1);
            check({tag, "_baddr"}, bus.data_addr, v.addr);
            check({tag, "_wr"}, {31'b0, bus.data_wr}, {31'b0, v.exp_wr});
            check({tag, "_size"}, {30'b0, bus.data_size}, {30'b0, v.exp_size});
            if (v.exp_wr) begin
                check({tag, "_strb"}, {28'b0, bus.data_wstrb}, {28'b0, v.exp_strb});
                check({tag, "_bwdata"}, bus.data_wdata, v.exp_bdata);
            end
            bus.data_addr_ok = 1'b1;
            if (v.lat == 0) begin
                bus.data_data_ok = 1'b1;
                bus.data_rdata   = v.rdata;
            end
            @(negedge clk);
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            if (v.lat > 0) begin
                check({tag, "_wait_req"}, {31'b0, bus.data_req}, 32'd0);
                repeat (v.lat - 1) @(negedge clk);
                check({tag, "_wait_valid"}, {31'b0, out_valid}, 32'd0);
                bus.data_data_ok = 1'b1;
                bus.data_rdata   = v.rdata;
                @(negedge clk);
                bus.data_data_ok = 1'b0;
            end
        end else begin
            check({tag, "_noreq"}, {31'b0, bus.data_req}, 32'd0);
        end
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_we"}, {31'b0, out_rf_we}, {31'b0, v.exp_we});
        check({tag, "_waddr"}, {27'b0, out_rf_waddr}, {27'b0, v.waddr});
        check({tag, "_exc"}, {27'b0, out_exc}, {27'b0, v.exp_exc});
        check({tag, "_bad"}, out_badvaddr, v.exp_bad);
        begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (v.chk_wdata) check({tag, "_wdata"}, out_rf_wdata, e);
        end
        // Result must hold while WB stalls.
        @(negedge clk);
        check({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_hold_exc"}, {27'b0, out_exc}, {27'b0, v.exp_exc});
        wb_take();
    endtask

    // ---------------- test ----------------
    initial begin
        logic early;
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive_idle();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;

        // Fields: op addr wdata rf_we waddr rdata lat | req wr size strb bdata | we chk res exc bad
        vecs[0]  = '{OP_NONE, 32'h1234_5678, 32'h0, 1'b1, 5'd3, 32'h0, 0,
                     1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h1234_5678, 5'h00, 32'h0};
        vecs[1]  = '{OP_LB, 32'h0000_1003, 32'h0, 1'b1, 5'd5, 32'h80FF_0000, 3,
                     1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FF80, 5'h00, 32'h0};
        vecs[2]  = '{OP_LBU, 32'h0000_1003, 32'h0, 1'b1, 5'd6, 32'h80FF_0000, 3,
                     1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0080, 5'h00, 32'h0};
        vecs[3]  = '{OP_SH, 32'h0000_2002, 32'hAAAA_BEEF, 1'b1, 5'd4, 32'h0, 1,
                     1'b1, 1'b1, 2'd1, 4'hC, 32'hBEEF_BEEF, 1'b0, 1'b0, 32'h0, 5'h00, 32'h0};
        vecs[4]  = '{OP_LW, 32'h0000_3001, 32'h0, 1'b1, 5'd8, 32'h0, 0,
                     1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'h04, 32'h0000_3001};
        vecs[5]  = '{OP_SW, 32'h0000_3002, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 0,
                     1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'h05, 32'h0000_3002};
        vecs[6]  = '{OP_LH, 32'h0000_4002, 32'h0, 1'b1, 5'd11, 32'h8001_7FFF, 0,
                     1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_8001, 5'h00, 32'h0};
        vecs[7]  = '{OP_LHU, 32'h0000_4002, 32'h0, 1'b1, 5'd12, 32'h8001_7FFF, 0,
                     1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0000_8001, 5'h00, 32'h0};
        vecs[8]  = '{OP_LH, 32'h0000_4000, 32'h0, 1'b1, 5'd12, 32'h8001_7FFF, 2,
                     1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0000_7FFF, 5'h00, 32'h0};
        vecs[9]  = '{OP_LW, 32'h0000_5000, 32'h0, 1'b1, 5'd13, 32'hDEAD_BEEF, 1,
                     1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'h00, 32'h0};
        vecs[10] = '{OP_SB, 32'h0000_6001, 32'h1234_56A5, 1'b0, 5'd0, 32'h0, 0,
                     1'b1, 1'b1, 2'd0, 4'h2, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0, 5'h00, 32'h0};
        vecs[11] = '{OP_SW, 32'h0000_6004, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0, 2,
                     1'b1, 1'b1, 2'd2, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 5'h00, 32'h0};
        vecs[12] = '{OP_LHU, 32'h0000_7003, 32'h0, 1'b1, 5'd9, 32'h0, 0,
                     1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'h04, 32'h0000_7003};
        vecs[13] = '{OP_SH, 32'h0000_7001, 32'h0, 1'b0, 5'd0, 32'h0, 0,
                     1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'h05, 32'h0000_7001};
        vecs[14] = '{4'd12, 32'h0000_00AA, 32'h0, 1'b0, 5'd7, 32'h0, 0,
                     1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_00AA, 5'h00, 32'h0};
        vecs[15] = '{OP_LB, 32'h0000_8001, 32'h0, 1'b1, 5'd14, 32'h0000_7F00, 1,
                     1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0000_007F, 5'h00, 32'h0};

        // Reset state
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data_req", {31'b0, bus.data_req}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // Table
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Timeout, then the next op waits for the late response to drain.
        accept_op(OP_LW, 32'h0000_9000, 32'h0, 1'b1, 5'd15);
        check("to_req", {31'b0, bus.data_req}, 32'd1);
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        early = 1'b0;
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            if (out_valid) early = 1'b1;
            @(negedge clk);
        end
        check("to_early", {31'b0, early}, 32'd0);
        check("to_valid", {31'b0, out_valid}, 32'd1);
        check("to_exc", {27'b0, out_exc}, 32'h07);
        check("to_bad", out_badvaddr, 32'h0000_9000);
        check("to_we", {31'b0, out_rf_we}, 32'd0);
        wb_take();
        accept_op(OP_LW, 32'h0000_A000, 32'h0, 1'b1, 5'd16);
        check("orph_req0", {31'b0, bus.data_req}, 32'd0);
        repeat (2) @(negedge clk);
        check("orph_req0_late", {31'b0, bus.data_req}, 32'd0);
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1111_1111;
        @(negedge clk);
        bus.data_data_ok = 1'b0;
        check("orph_discard", {31'b0, out_valid}, 32'd0);
        check("orph_req1", {31'b0, bus.data_req}, 32'd1);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h2222_2222;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        check("orph_valid", {31'b0, out_valid}, 32'd1);
        check("orph_wdata", out_rf_wdata, 32'h2222_2222);
        check("orph_exc", {27'b0, out_exc}, 32'd0);
        wb_take();

        // Flush in WAIT; stale response must not complete the next op.
        accept_op(OP_LW, 32'h0000_B000, 32'h0, 1'b1, 5'd17);
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        check("fw_state_wait", {30'b0, dbg_state}, 32'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fw_idle", {30'b0, dbg_state}, 32'd0);
        accept_op(OP_LW, 32'h0000_C000, 32'h0, 1'b1, 5'd10);
        check("fw_req0", {31'b0, bus.data_req}, 32'd0);
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h3333_3333;
        @(negedge clk);
        bus.data_data_ok = 1'b0;
        check("fw_stale_valid", {31'b0, out_valid}, 32'd0);
        check("fw_req1", {31'b0, bus.data_req}, 32'd1);
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h4444_4444;
        @(negedge clk);
        bus.data_data_ok = 1'b0;
        check("fw_valid", {31'b0, out_valid}, 32'd1);
        check("fw_wdata", out_rf_wdata, 32'h4444_4444);
        check("fw_waddr", {27'b0, out_rf_waddr}, 32'd10);
        wb_take();

        // Flush in REQ before addr_ok: no orphan, next request goes straight out.
        accept_op(OP_LW, 32'h0000_D000, 32'h0, 1'b1, 5'd18);
        check("fr_req", {31'b0, bus.data_req}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fr_req_drop", {31'b0, bus.data_req}, 32'd0);
        check("fr_idle", {30'b0, dbg_state}, 32'd0);
        accept_op(OP_LW, 32'h0000_D004, 32'h0, 1'b1, 5'd19);
        check("fr_req_next", {31'b0, bus.data_req}, 32'd1);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h5555_5555;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        check("fr_wdata", out_rf_wdata, 32'h5555_5555);
        wb_take();

        // Flush in RESP drops the result; flush in IDLE blocks accept.
        accept_op(OP_NONE, 32'h0000_0077, 32'h0, 1'b1, 5'd2);
        check("fresp_valid", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fresp_drop", {31'b0, out_valid}, 32'd0);
        flush = 1'b1;
        in_valid = 1'b1; in_op = OP_NONE; in_addr = 32'h88; in_rf_we = 1'b1;
        #1;
        check("fidle_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        drive_idle();
        flush = 1'b0;
        check("fidle_noacc", {31'b0, out_valid}, 32'd0);
        check("fidle_state", {30'b0, dbg_state}, 32'd0);

        // Asynchronous reset in WAIT.
        accept_op(OP_LW, 32'h0000_E000, 32'h0, 1'b1, 5'd20);
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        @(negedge clk);
        check("ar_wait", {30'b0, dbg_state}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("ar_state", {30'b0, dbg_state}, 32'd0);
        check("ar_req", {31'b0, bus.data_req}, 32'd0);
        check("ar_valid", {31'b0, out_valid}, 32'd0);
        check("ar_ready", {31'b0, in_ready}, 32'd0);
        check("ar_exc", {27'b0, out_exc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ar_rel_ready", {31'b0, in_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
